apb_master_module: RTL and testbench
====================================

# apb_master_module

APB requester that converts single host commands into APB SETUP/ACCESS transfers toward the matmul APB slave and returns read data and an error status to the host. It sits between the host/testbench command source and the APB bus, and is the initiator counterpart of the team's APB slave. A programmable wait-state timeout terminates transfers whose slave never asserts `pready_i`.

## Interface
- `BUS_WIDTH`, 64: APB data width in bits; strobe width is BUS_WIDTH/8.
- `ADDR_WIDTH`, 32: APB address width in bits.
- `TIMEOUT_CYCLES`, 16: maximum ACCESS cycles before the transfer is aborted; 0 disables the timeout.

Ports:
- `clk_i` in 1: single clock; all logic is rising-edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `cmd_valid_i` in 1: host command valid.
- `cmd_ready_o` out 1: host command accepted while high.
- `cmd_write_i` in 1: 1 = write, 0 = read.
- `cmd_addr_i` in ADDR_WIDTH: transfer address.
- `cmd_wdata_i` in BUS_WIDTH: write data.
- `cmd_strb_i` in BUS_WIDTH/8: write byte strobes.
- `rsp_valid_o` out 1: one-cycle pulse when a transfer completes.
- `rsp_rdata_o` out BUS_WIDTH: read data; held until the next response.
- `rsp_err_o` out 1: slave error or timeout, valid with `rsp_valid_o`.
- `rsp_timeout_o` out 1: set when the transfer was aborted by the timeout, valid with `rsp_valid_o`.
- `busy_o` out 1: high from command acceptance until the response pulse.
- `psel_o`, `penable_o`, `pwrite_o` out 1: APB control.
- `paddr_o` out ADDR_WIDTH, `pwdata_o` out BUS_WIDTH, `pstrb_o` out BUS_WIDTH/8: APB request.
- `pready_i`, `pslverr_i` in 1, `prdata_i` in BUS_WIDTH: APB completion.

## Operation
- States: IDLE, SETUP, ACCESS.
- **IDLE:** `cmd_ready_o`=1. When `cmd_valid_i` is high at the edge, register write, addr, wdata and strb, then go to SETUP.
- **Read strobes:** on a read, `pstrb_o` is forced to 0, because the slave errors on nonzero read strobes. On a read, `pwdata_o` is 0.
- **SETUP:** `psel_o`=1, `penable_o`=0, all request signals stable. Unconditionally go to ACCESS.
- **ACCESS:** `psel_o`=1, `penable_o`=1, request held stable. The wait counter increments each cycle.
- **Completion:** `pready_i`=1 at the edge means the transfer completes.
  - Capture `prdata_i` into `rsp_rdata_o` on reads only; writes leave it unchanged.
  - `rsp_err_o` takes `pslverr_i`.
  - Pulse `rsp_valid_o` and go to IDLE.
- **Timeout:** if TIMEOUT_CYCLES≠0, the counter reaches TIMEOUT_CYCLES and `pready_i` is still 0, then pulse `rsp_valid_o` with `rsp_err_o`=1 and `rsp_timeout_o`=1, and go to IDLE. `rsp_rdata_o` is unchanged.
- **Simultaneous events:** if `pready_i` arrives on the same edge as the timeout, `pready_i` wins (normal completion).
- **`pslverr_i` qualification:** `pslverr_i` and `prdata_i` are ignored outside ACCESS && `pready_i`.
- **Command inputs while busy:** ignored; `cmd_ready_o`=0.
- **Counter width:** $clog2(TIMEOUT_CYCLES+1). The counter saturates, never wraps, and clears on entering SETUP.

## Timing
- **Reset values:** all outputs are 0, the state is IDLE and the counter is 0, with one exception: `cmd_ready_o` goes to 1 once reset releases.
- **Reset mid-operation:** `rst_i` forces `psel_o`/`penable_o` low immediately (asynchronous), with no response pulse.
- **Per-cycle sequence:** command accepted at edge N. Cycle N+1 is SETUP. Cycle N+2 is the first ACCESS cycle.
- **Latency:** with zero wait states, `pready_i` is sampled at the end of N+2 and `rsp_valid_o` is high in cycle N+3. Each wait state adds one cycle.
- **Back-to-back:** `cmd_ready_o` is high in the same cycle as `rsp_valid_o`, so a new command can be accepted there. The minimum transfer period is 3 cycles.
- **Bus idle:** `psel_o` is 0 in every IDLE cycle.
- **`busy_o`:** high from N+1 until the cycle before `rsp_valid_o`, inclusive.

## Structure
- **Shared package `apb_pkg`:**
  - 2-bit state encoding: IDLE=00, SETUP=01, ACCESS=10.
  - Default BUS_WIDTH/ADDR_WIDTH constants.
  - Strobe width derivation.
  - Shared by both APB master and slave.
- **Sub-module `apb_timeout_counter`:** saturating counter with clear/enable and an `expired` flag. It is the only natural split; the FSM and datapath stay in the top module.

## Test plan
- **Write, zero wait:** write addr 0x10, data 0x1122334455667788, strb 0xFF. Expect `psel_o` in N+1, `penable_o` in N+2, `pwrite_o`=1, `rsp_valid_o` in N+3 and `rsp_err_o`=0.
- **Read, 1 wait state:** read addr 0x10 with `pready_i` high only in the second ACCESS cycle and `prdata_i`=0xDEADBEEF. Expect `pstrb_o`=0, `rsp_rdata_o`=0xDEADBEEF, and `rsp_valid_o` in N+4.
- **Slave error:** `pslverr_i`=1 with `pready_i` on a read. Expect `rsp_err_o`=1, `rsp_timeout_o`=0, and `rsp_rdata_o` updated.
- **Timeout:** TIMEOUT_CYCLES=4 with `pready_i` stuck at 0. Expect exactly 4 ACCESS cycles, then `rsp_err_o`=`rsp_timeout_o`=1 and `psel_o` low. A second run has `pready_i` arriving on the 4th cycle and expects a normal completion.
- **Back-to-back and reset:** hold `cmd_valid_i` high for two commands and expect acceptance in the `rsp_valid_o` cycle with a 3-cycle period. Assert `rst_i` during ACCESS and expect `psel_o`/`penable_o` low before the next edge, with no `rsp_valid_o`.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions used by both the APB master and the APB slave:
// state encoding, default bus widths and derived-width helpers.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10
    } apb_state_t;

    localparam int APB_BUS_WIDTH  = 64;
    localparam int APB_ADDR_WIDTH = 32;

    function automatic int strb_width(input int bus_width);
        return bus_width / 8;
    endfunction

    // A zero limit still needs a one-bit counter so the ports stay legal.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/apb_master_module_if.sv
// Host command/response channel plus APB requester bus for apb_master_module.
// The master modport is the requester; the slave modport is its counterpart.
interface apb_master_module_if
    import apb_pkg::*;
#(
    parameter int BUS_WIDTH  = APB_BUS_WIDTH,
    parameter int ADDR_WIDTH = APB_ADDR_WIDTH
);
    localparam int STRB_WIDTH = strb_width(BUS_WIDTH);

    // Command handshake: a command transfers on a rising edge where
    // cmd_valid_i and cmd_ready_o are both high; nothing else is sampled.
    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic                  cmd_write_i;
    logic [ADDR_WIDTH-1:0] cmd_addr_i;
    logic [BUS_WIDTH-1:0]  cmd_wdata_i;
    logic [STRB_WIDTH-1:0] cmd_strb_i;

    logic                  rsp_valid_o;
    logic [BUS_WIDTH-1:0]  rsp_rdata_o;
    logic                  rsp_err_o;
    logic                  rsp_timeout_o;
    logic                  busy_o;

    logic                  psel_o;
    logic                  penable_o;
    logic                  pwrite_o;
    logic [ADDR_WIDTH-1:0] paddr_o;
    logic [BUS_WIDTH-1:0]  pwdata_o;
    logic [STRB_WIDTH-1:0] pstrb_o;
    logic                  pready_i;
    logic                  pslverr_i;
    logic [BUS_WIDTH-1:0]  prdata_i;

    apb_state_t            state_o;

    modport master (
        input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i,
        input  pready_i, pslverr_i, prdata_i,
        output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o, busy_o,
        output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o,
        output state_o
    );

    modport slave (
        output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i,
        output pready_i, pslverr_i, prdata_i,
        input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o, busy_o,
        input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o,
        input  state_o
    );

endinterface

// File: rtl/apb_timeout_counter.sv
// Saturating ACCESS-cycle counter; expired marks the last ACCESS cycle allowed
// before the transfer is aborted. LIMIT of 0 never expires.
module apb_timeout_counter
    import apb_pkg::*;
#(
    parameter int LIMIT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int            CW   = cnt_width(LIMIT);
    localparam logic [CW-1:0] SAT  = CW'(LIMIT);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en && (count_q != SAT)) begin
            count_q <= count_q + 1'b1;
        end
    end

    // count_q holds the ACCESS cycles already finished, so the current
    // cycle is number count_q+1.
    assign expired = (LIMIT != 0) && en && (count_q >= LAST);

endmodule

// File: rtl/apb_master_module.sv
// APB requester: turns one host command into a SETUP/ACCESS transfer and
// returns read data, slave error and timeout status as a one-cycle response.
module apb_master_module
    import apb_pkg::*;
#(
    parameter int BUS_WIDTH      = APB_BUS_WIDTH,
    parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic                 clk_i,
    input logic                 rst_i,
    apb_master_module_if.master bus
);
    localparam int STRB_WIDTH = strb_width(BUS_WIDTH);

    apb_state_t            state_q;
    apb_state_t            state_d;
    logic                  accept;
    logic                  done_ok;
    logic                  done_to;
    logic                  expired;

    logic                  write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [BUS_WIDTH-1:0]  wdata_q;
    logic [STRB_WIDTH-1:0] strb_q;

    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic                  rsp_timeout_q;
    logic [BUS_WIDTH-1:0]  rdata_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A ready slave beats an expiring counter on the same edge.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        done_ok = 1'b0;
        done_to = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid_i) begin
                    accept  = 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (bus.pready_i) begin
                    done_ok = 1'b1;
                    state_d = ST_IDLE;
                end else if (expired) begin
                    done_to = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    apb_timeout_counter #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr    (accept),
        .en     (state_q == ST_ACCESS),
        .expired(expired)
    );

    // Reads carry zero data and zero strobes; the slave rejects read strobes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else if (accept) begin
            write_q <= bus.cmd_write_i;
            addr_q  <= bus.cmd_addr_i;
            wdata_q <= bus.cmd_write_i ? bus.cmd_wdata_i : '0;
            strb_q  <= bus.cmd_write_i ? bus.cmd_strb_i : '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rdata_q       <= '0;
        end else begin
            rsp_valid_q <= done_ok | done_to;
            if (done_ok) begin
                rsp_err_q     <= bus.pslverr_i;
                rsp_timeout_q <= 1'b0;
                if (!write_q) begin
                    rdata_q <= bus.prdata_i;
                end
            end else if (done_to) begin
                rsp_err_q     <= 1'b1;
                rsp_timeout_q <= 1'b1;
            end
        end
    end

    assign bus.cmd_ready_o   = (state_q == ST_IDLE) && !rst_i;
    assign bus.busy_o        = (state_q != ST_IDLE);
    assign bus.psel_o        = (state_q != ST_IDLE);
    assign bus.penable_o     = (state_q == ST_ACCESS);
    assign bus.pwrite_o      = write_q;
    assign bus.paddr_o       = addr_q;
    assign bus.pwdata_o      = wdata_q;
    assign bus.pstrb_o       = strb_q;
    assign bus.rsp_valid_o   = rsp_valid_q;
    assign bus.rsp_err_o     = rsp_err_q;
    assign bus.rsp_timeout_o = rsp_timeout_q;
    assign bus.rsp_rdata_o   = rdata_q;
    assign bus.state_o       = state_q;

endmodule

// File: tb/tb_apb_master_module.sv
// Bench for apb_master_module: table of directed transfers, randomized
// transfers against a latency/response model, back-to-back and reset sequences.
module tb_apb_master_module;
    import apb_pkg::*;

    localparam int BW = 64;
    localparam int AW = 32;
    localparam int SW = BW / 8;
    localparam int TO = 4;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [BW-1:0] wdata;
        logic [SW-1:0] strb;
        int            waits;
        logic          slverr;
        logic [BW-1:0] rdata;
        int            exp_lat;
        logic          exp_err;
        logic          exp_to;
        logic [BW-1:0] exp_rdata;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [BW-1:0] model_rdata = '0;
    logic [BW-1:0] exp_q[$];

    always #5 clk = ~clk;

    apb_master_module_if #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW)) bus ();

    apb_master_module #(
        .BUS_WIDTH     (BW),
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.cmd_valid_i = 1'b0;
        bus.cmd_write_i = 1'b0;
        bus.cmd_addr_i  = '0;
        bus.cmd_wdata_i = '0;
        bus.cmd_strb_i  = '0;
        bus.pready_i    = 1'b0;
        bus.pslverr_i   = 1'b0;
        bus.prdata_i    = '0;
    endtask

    // Noise on the completion inputs; it must be ignored outside ACCESS && pready.
    task automatic junk_apb();
        bus.pready_i  = 1'b0;
        bus.pslverr_i = 1'($urandom_range(0, 1));
        bus.prdata_i  = {$urandom(), $urandom()};
    endtask

    function automatic vec_t mk(input logic wr, input logic [AW-1:0] addr, input logic [BW-1:0] wdata,
                                input logic [SW-1:0] strb, input int waits, input logic slverr,
                                input logic [BW-1:0] rdata, input int lat, input logic err,
                                input logic to, input logic [BW-1:0] exp_rdata);
        vec_t r;
        r.wr = wr; r.addr = addr; r.wdata = wdata; r.strb = strb; r.waits = waits;
        r.slverr = slverr; r.rdata = rdata; r.exp_lat = lat; r.exp_err = err;
        r.exp_to = to; r.exp_rdata = exp_rdata;
        return r;
    endfunction

    // Reference: the slave answers on ACCESS cycle waits+1 unless the
    // timeout budget of TO ACCESS cycles runs out first.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int   acc;
        r = v;
        acc = v.waits + 1;
        r.exp_to    = (acc > TO);
        r.exp_lat   = 2 + (r.exp_to ? TO : acc);
        r.exp_err   = r.exp_to ? 1'b1 : v.slverr;
        r.exp_rdata = (!v.wr && !r.exp_to) ? v.rdata : model_rdata;
        return r;
    endfunction

    // Entered and left at a negedge; the cycle of entry is acceptance cycle N.
    task automatic run_txn(input vec_t v, input string tag);
        logic [BW-1:0] want;
        exp_q.push_back(v.exp_rdata);
        chk({tag, " cmd_ready@N"}, bus.cmd_ready_o, 1'b1);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = v.wr;
        bus.cmd_addr_i  = v.addr;
        bus.cmd_wdata_i = v.wdata;
        bus.cmd_strb_i  = v.strb;
        junk_apb();
        for (int off = 1; off <= 40; off++) begin
            @(negedge clk);
            if (off == v.exp_lat) begin
                want = exp_q.pop_front();
                chk({tag, " rsp_valid"}, bus.rsp_valid_o, 1'b1);
                chk({tag, " rsp_err"}, bus.rsp_err_o, v.exp_err);
                chk({tag, " rsp_timeout"}, bus.rsp_timeout_o, v.exp_to);
                chk({tag, " rsp_rdata"}, bus.rsp_rdata_o, want);
                chk({tag, " psel@rsp"}, bus.psel_o, 1'b0);
                chk({tag, " busy@rsp"}, bus.busy_o, 1'b0);
                chk({tag, " cmd_ready@rsp"}, bus.cmd_ready_o, 1'b1);
                bus.cmd_valid_i = 1'b0;
                bus.pready_i    = 1'b0;
                model_rdata     = v.exp_rdata;
                break;
            end
            chk($sformatf("%s rsp_valid@%0d", tag, off), bus.rsp_valid_o, 1'b0);
            chk($sformatf("%s psel@%0d", tag, off), bus.psel_o, 1'b1);
            chk($sformatf("%s penable@%0d", tag, off), bus.penable_o, (off >= 2));
            chk($sformatf("%s busy@%0d", tag, off), bus.busy_o, 1'b1);
            chk($sformatf("%s cmd_ready@%0d", tag, off), bus.cmd_ready_o, 1'b0);
            if (off == 1) begin
                chk({tag, " paddr"}, bus.paddr_o, v.addr);
                chk({tag, " pwrite"}, bus.pwrite_o, v.wr);
                chk({tag, " pwdata"}, bus.pwdata_o, v.wr ? v.wdata : '0);
                chk({tag, " pstrb"}, bus.pstrb_o, v.wr ? v.strb : '0);
            end
            if (off + 1 == v.exp_lat) begin
                bus.cmd_valid_i = 1'b0;
            end else begin
                bus.cmd_valid_i = 1'($urandom_range(0, 1));
            end
            bus.cmd_write_i = 1'($urandom_range(0, 1));
            bus.cmd_addr_i  = $urandom();
            bus.cmd_wdata_i = {$urandom(), $urandom()};
            bus.cmd_strb_i  = 8'($urandom_range(0, 255));
            if (off >= 2 && (off - 1) == v.waits + 1) begin
                bus.pready_i  = 1'b1;
                bus.pslverr_i = v.slverr;
                bus.prdata_i  = v.rdata;
            end else begin
                junk_apb();
            end
        end
    endtask

    initial begin
        vec_t tbl[7];
        vec_t v;
        logic [6:0] psel_pat;
        logic [6:0] pen_pat;
        logic [6:0] rsp_pat;
        logic [6:0] rdy_pat;

        tbl[0] = mk(1'b1, 32'h10, 64'h1122334455667788, 8'hFF, 0, 1'b0, 64'h0, 3, 1'b0, 1'b0, 64'h0);
        tbl[1] = mk(1'b0, 32'h10, 64'hAAAA, 8'hFF, 1, 1'b0, 64'hDEADBEEF, 4, 1'b0, 1'b0, 64'hDEADBEEF);
        tbl[2] = mk(1'b0, 32'h20, 64'h0, 8'h00, 0, 1'b1, 64'hCAFE, 3, 1'b1, 1'b0, 64'hCAFE);
        tbl[3] = mk(1'b0, 32'h30, 64'h0, 8'h00, 9, 1'b0, 64'h5555, 6, 1'b1, 1'b1, 64'hCAFE);
        tbl[4] = mk(1'b0, 32'h40, 64'h0, 8'h00, 3, 1'b0, 64'h1234, 6, 1'b0, 1'b0, 64'h1234);
        tbl[5] = mk(1'b1, 32'h50, 64'h0F0F, 8'h0F, 2, 1'b1, 64'h9999, 5, 1'b1, 1'b0, 64'h1234);
        tbl[6] = mk(1'b1, 32'h60, 64'h77, 8'h01, 20, 1'b0, 64'h8888, 6, 1'b1, 1'b1, 64'h1234);

        idle_inputs();
        repeat (2) @(negedge clk);
        chk("reset cmd_ready", bus.cmd_ready_o, 1'b0);
        chk("reset psel", bus.psel_o, 1'b0);
        chk("reset penable", bus.penable_o, 1'b0);
        chk("reset rsp_valid", bus.rsp_valid_o, 1'b0);
        chk("reset busy", bus.busy_o, 1'b0);
        chk("reset rsp_err", bus.rsp_err_o, 1'b0);
        chk("reset rsp_timeout", bus.rsp_timeout_o, 1'b0);
        chk("reset rsp_rdata", bus.rsp_rdata_o, '0);
        chk("reset paddr", bus.paddr_o, '0);
        chk("reset pwrite", bus.pwrite_o, 1'b0);
        chk("reset pwdata", bus.pwdata_o, '0);
        chk("reset pstrb", bus.pstrb_o, '0);
        chk("reset state", bus.state_o, ST_IDLE);
        rst = 1'b0;
        #1;
        chk("release cmd_ready", bus.cmd_ready_o, 1'b1);
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_txn(tbl[i], $sformatf("vec%0d", i));
            @(negedge clk);
            chk($sformatf("vec%0d idle psel", i), bus.psel_o, 1'b0);
        end

        for (int i = 0; i < 40; i++) begin
            v.wr     = 1'($urandom_range(0, 1));
            v.addr   = $urandom();
            v.wdata  = {$urandom(), $urandom()};
            v.strb   = 8'($urandom_range(0, 255));
            v.waits  = $urandom_range(0, 6);
            v.slverr = 1'($urandom_range(0, 1));
            v.rdata  = {$urandom(), $urandom()};
            v = model(v);
            run_txn(v, $sformatf("rnd%0d", i));
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                chk($sformatf("rnd%0d idle psel", i), bus.psel_o, 1'b0);
            end
        end

        // Two commands with cmd_valid held: second accepted in the response cycle.
        @(negedge clk);
        psel_pat = 7'b0110110;
        pen_pat  = 7'b0100100;
        rsp_pat  = 7'b1001000;
        rdy_pat  = 7'b1001001;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = 1'b1;
        bus.cmd_addr_i  = 32'h100;
        bus.cmd_wdata_i = 64'h1;
        bus.cmd_strb_i  = 8'hFF;
        bus.pready_i    = 1'b1;
        bus.pslverr_i   = 1'b0;
        for (int off = 0; off <= 6; off++) begin
            chk($sformatf("b2b psel@%0d", off), bus.psel_o, psel_pat[off]);
            chk($sformatf("b2b penable@%0d", off), bus.penable_o, pen_pat[off]);
            chk($sformatf("b2b rsp_valid@%0d", off), bus.rsp_valid_o, rsp_pat[off]);
            chk($sformatf("b2b cmd_ready@%0d", off), bus.cmd_ready_o, rdy_pat[off]);
            if (off == 1) chk("b2b paddr first", bus.paddr_o, 64'h100);
            if (off == 4) chk("b2b paddr second", bus.paddr_o, 64'h200);
            if (off == 3 || off == 6) chk($sformatf("b2b rsp_err@%0d", off), bus.rsp_err_o, 1'b0);
            if (off == 1) bus.cmd_addr_i = 32'h200;
            if (off == 4) bus.cmd_valid_i = 1'b0;
            @(negedge clk);
        end
        idle_inputs();
        @(negedge clk);

        // Reset while the slave is stalling in ACCESS.
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = 1'b0;
        bus.cmd_addr_i  = 32'h300;
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        @(negedge clk);
        chk("rst pre penable", bus.penable_o, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst async psel", bus.psel_o, 1'b0);
        chk("rst async penable", bus.penable_o, 1'b0);
        chk("rst async busy", bus.busy_o, 1'b0);
        chk("rst async rsp_valid", bus.rsp_valid_o, 1'b0);
        @(negedge clk);
        chk("rst rsp_rdata cleared", bus.rsp_rdata_o, '0);
        rst = 1'b0;
        model_rdata = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("post-rst rsp_valid@%0d", c), bus.rsp_valid_o, 1'b0);
            chk($sformatf("post-rst psel@%0d", c), bus.psel_o, 1'b0);
            chk($sformatf("post-rst cmd_ready@%0d", c), bus.cmd_ready_o, 1'b1);
        end
        v = mk(1'b0, 32'h310, 64'h0, 8'h00, 1, 1'b0, 64'h4242, 0, 1'b0, 1'b0, 64'h0);
        v = model(v);
        run_txn(v, "post-rst read");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
